viterbi_ctrl: RTL and testbench
===============================

Name: viterbi_ctrl

Overview:
Top-level sequencing FSM for the Viterbi decoder datapath.
- Accepts a block of TRACEBACK_DEPTH input symbols over a valid/ready handshake.
- Steps branch-metric/ACS/survivor-store once per accepted symbol.
- Then latches the minimum-metric node, runs the traceback unit to completion and presents the decoded word downstream over a valid/ready handshake.
- Sits between the symbol source, the ACS/survivor datapath and the traceback unit.

Parameters:
TRACEBACK_DEPTH, 16, symbols per block; decoded word is TRACEBACK_DEPTH*2 bits; legal range 2..63.
CNT_W, 7, width of symbol/step counters; must satisfy 2^CNT_W > TRACEBACK_DEPTH*2.
TO_CYCLES, TRACEBACK_DEPTH+4, watchdog limit in TRACE (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
i_start  in  1  begin a new block; sampled in IDLE only
i_sym_valid  in  1  input symbol valid
o_sym_ready  out  1  controller accepts symbol this cycle
o_en_acs  out  1  datapath step enable (branch metric, ACS, survivor write); one pulse per accepted symbol
o_en_sel  out  1  one-cycle pulse: datapath latches minimum-metric node into the traceback start register
o_tb_rst  out  1  active-low restart to traceback unit
o_en_t  out  1  traceback enable
i_tb_done  in  1  traceback unit done flag
o_out_valid  out  1  decoded word available
i_out_ready  in  1  downstream accepts decoded word
o_busy  out  1  high in any state except IDLE
o_sym_cnt  out  CNT_W  symbols accepted in current block
o_err  out  1  sticky watchdog error

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, o_sym_cnt=0, o_err=0. All enables/valid/ready are 0, o_tb_rst=0, o_busy=0.
- Outputs are registered and decoded from state, except o_sym_ready and o_en_acs.
  - o_sym_ready = (state==FILL).
  - o_en_acs = o_sym_ready & i_sym_valid, combinational. Same-cycle acceptance; no bubble between consecutive symbols.
- States:
  - IDLE: o_tb_rst=0 (traceback held in reset). On i_start=1, go to FILL and clear o_sym_cnt.
  - FILL: each handshake increments o_sym_cnt. A handshake with o_sym_cnt==TRACEBACK_DEPTH-1 goes to SEL. i_sym_valid=0 stalls indefinitely; no timeout.
  - SEL: exactly one cycle. o_en_sel=1, o_tb_rst=0. Next state is TRACE.
  - TRACE: o_tb_rst=1, o_en_t=1. On i_tb_done=1, deassert o_en_t next cycle and go to HOLD. The traceback needs TRACEBACK_DEPTH enabled cycles, so nominal TRACE length is TRACEBACK_DEPTH+1 cycles.
  - HOLD: o_out_valid=1, o_tb_rst=1, o_en_t=0 (traceback output word stable). On i_out_ready=1, go to IDLE.
- Block latency: start-to-first-ready is 1 cycle. Last symbol to o_out_valid is TRACEBACK_DEPTH+3 cycles with immediate i_tb_done.
- i_start is ignored outside IDLE and is not queued. i_start and i_out_ready both high in HOLD: the block completes; a new block needs i_start again in IDLE.
- o_out_valid, once high, stays high until the handshake. It never drops while i_out_ready=0.
- i_tb_done outside TRACE is ignored.
- Reset mid-operation from any state: immediate return to reset values. The partial block is discarded and the datapath is not flushed.
- o_sym_cnt holds its final value (TRACEBACK_DEPTH) through SEL/TRACE/HOLD and clears on the next start.

Optional Feature:
VITERBI_CTRL_WATCHDOG_EN
- Defined: TRACE has a cycle counter. If i_tb_done is not seen within TO_CYCLES cycles, go to IDLE without asserting o_out_valid and set o_err=1. o_err is sticky and cleared only by reset.
- Undefined: no counter; TRACE waits indefinitely; o_err tied to 0.

Decomposition:
- Shared package viterbi_pkg:
  - state enum ctrl_state_t {IDLE, FILL, SEL, TRACE, HOLD}
  - TRACEBACK_DEPTH and derived DEC_W = TRACEBACK_DEPTH*2
  - CNT_W
- One sub-module, viterbi_wdog: a loadable down-counter with an expiry flag, instantiated only under the macro. All else stays in one FSM module.

Test Plan:
1. Reset mid-TRACE (rst=0 one cycle) -> next cycle state IDLE, o_busy=0, o_en_t=0, o_tb_rst=0, o_sym_cnt=0.
2. TRACEBACK_DEPTH=16, i_start then 16 back-to-back valid symbols -> 16 o_en_acs pulses, o_en_sel exactly one cycle after the 16th, o_en_t rises the following cycle.
3. Valid gaps (valid high 1 of every 3 cycles) -> o_en_acs count stays 16, o_sym_cnt steps 0..16, no extra pulses.
4. i_tb_done after 16 TRACE cycles with i_out_ready=0 for 5 cycles -> o_out_valid held 5+ cycles, drops the cycle after ready, state IDLE.
5. i_start pulsed during FILL and HOLD -> ignored; block count unaffected.
6. Macro defined, i_tb_done never asserted -> after 20 TRACE cycles: IDLE, o_err=1, o_out_valid never 1; o_err persists across the next block.

Source files
------------

// File: rtl/viterbi_pkg.sv
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared types and sizing for the Viterbi decoder control path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package viterbi_pkg;

    localparam int TRACEBACK_DEPTH = 16;
    localparam int DEC_W           = TRACEBACK_DEPTH * 2;
    localparam int CNT_W           = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SEL   = 3'd2,
        TRACE = 3'd3,
        HOLD  = 3'd4
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/viterbi_ctrl_if.sv
// ============================================================================
// Module      : viterbi_ctrl_if
// Description : Handshake/enable bundle between the sequencing controller
//               (master) and the symbol source / datapath / sink (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface viterbi_ctrl_if #(
    parameter int CNT_W = viterbi_pkg::CNT_W
);
    logic             i_start;
    logic             i_sym_valid;
    logic             o_sym_ready;
    logic             o_en_acs;
    logic             o_en_sel;
    logic             o_tb_rst;
    logic             o_en_t;
    logic             i_tb_done;
    logic             o_out_valid;
    logic             i_out_ready;
    logic             o_busy;
    logic [CNT_W-1:0] o_sym_cnt;
    logic             o_err;

    modport master (
        input  i_start, i_sym_valid, i_tb_done, i_out_ready,
        output o_sym_ready, o_en_acs, o_en_sel, o_tb_rst, o_en_t,
               o_out_valid, o_busy, o_sym_cnt, o_err
    );

    modport slave (
        output i_start, i_sym_valid, i_tb_done, i_out_ready,
        input  o_sym_ready, o_en_acs, o_en_sel, o_tb_rst, o_en_t,
               o_out_valid, o_busy, o_sym_cnt, o_err
    );
endinterface

`default_nettype wire

// File: rtl/viterbi_wdog.sv
// ============================================================================
// Module      : viterbi_wdog
// Description : Loadable down-counter; o_expired is high once it reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_wdog #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/viterbi_ctrl.sv
// ============================================================================
// Module      : viterbi_ctrl
// Description : Block sequencer for the Viterbi datapath: symbol fill, min-node
//               select, traceback and output hold. Optional TRACE watchdog
//               enabled by VITERBI_CTRL_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_ctrl #(
    parameter int TRACEBACK_DEPTH = viterbi_pkg::TRACEBACK_DEPTH,
    parameter int CNT_W           = viterbi_pkg::CNT_W
`ifdef VITERBI_CTRL_WATCHDOG_EN
    ,
    parameter int TO_CYCLES       = TRACEBACK_DEPTH + 4
`endif
) (
    input  logic            clk,
    input  logic            rst,
    viterbi_ctrl_if.master  bus
);

    import viterbi_pkg::*;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TRACEBACK_DEPTH - 1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next;
    logic [CNT_W-1:0] r_sym_cnt;
    logic             r_en_sel;
    logic             r_tb_rst;
    logic             r_en_t;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_sym_ready;
    logic             w_handshake;
    logic             w_expired;

    assign w_sym_ready = (r_state == FILL);
    assign w_handshake = w_sym_ready & bus.i_sym_valid;

`ifdef VITERBI_CTRL_WATCHDOG_EN
    localparam logic [CNT_W-1:0] c_to_load = CNT_W'(TO_CYCLES - 1);

    logic r_err;

    // Loaded during SEL so TRACE lasts exactly TO_CYCLES cycles before expiry.
    viterbi_wdog #(
        .CNT_W      (CNT_W)
    ) u_wdog (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == SEL),
        .i_load_val (c_to_load),
        .i_en       (r_state == TRACE),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if ((r_state == TRACE) && !bus.i_tb_done && w_expired) begin
            r_err <= 1'b1;
        end
    end

    assign bus.o_err = r_err;
`else
    assign w_expired = 1'b0;
    assign bus.o_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.i_start) w_next = FILL;
            FILL:    if (w_handshake && (r_sym_cnt == c_last)) w_next = SEL;
            SEL:     w_next = TRACE;
            TRACE: begin
                if (bus.i_tb_done)  w_next = HOLD;
                else if (w_expired) w_next = IDLE;
            end
            HOLD:    if (bus.i_out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_sym_cnt   <= '0;
            r_en_sel    <= 1'b0;
            r_tb_rst    <= 1'b0;
            r_en_t      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_en_sel    <= (w_next == SEL);
            r_tb_rst    <= (w_next == TRACE) || (w_next == HOLD);
            r_en_t      <= (w_next == TRACE);
            r_out_valid <= (w_next == HOLD);
            r_busy      <= (w_next != IDLE);
            if ((r_state == IDLE) && bus.i_start) begin
                r_sym_cnt <= '0;
            end else if (w_handshake) begin
                r_sym_cnt <= r_sym_cnt + 1'b1;
            end
        end
    end

    assign bus.o_sym_ready = w_sym_ready;
    assign bus.o_en_acs    = w_handshake;
    assign bus.o_en_sel    = r_en_sel;
    assign bus.o_tb_rst    = r_tb_rst;
    assign bus.o_en_t      = r_en_t;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_busy      = r_busy;
    assign bus.o_sym_cnt   = r_sym_cnt;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_ctrl.sv
// ============================================================================
// Module      : tb_viterbi_ctrl
// Description : Directed self-checking bench for viterbi_ctrl (depth 16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_viterbi_ctrl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   n_acs;
    int   n_sel;
    int   n_ov;

    viterbi_ctrl_if ifc ();

    viterbi_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs are set at the falling edge; sample just after, then wait one full cycle.
    task automatic step();
        #1;
        if (ifc.o_en_acs)    n_acs++;
        if (ifc.o_en_sel)    n_sel++;
        if (ifc.o_out_valid) n_ov++;
        @(negedge clk);
    endtask

    task automatic start_and_fill();
        ifc.i_start = 1'b1;
        step();
        ifc.i_start     = 1'b0;
        ifc.i_sym_valid = 1'b1;
        repeat (16) step();
        ifc.i_sym_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_err = 0; n_acs = 0; n_sel = 0; n_ov = 0;
        rst             = 1'b0;
        ifc.i_start     = 1'b0;
        ifc.i_sym_valid = 1'b0;
        ifc.i_tb_done   = 1'b0;
        ifc.i_out_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        check("rst_busy",   ifc.o_busy,      0);
        check("rst_cnt",    ifc.o_sym_cnt,   0);
        check("rst_tbrst",  ifc.o_tb_rst,    0);
        check("rst_en_t",   ifc.o_en_t,      0);
        check("rst_ovalid", ifc.o_out_valid, 0);
        check("rst_err",    ifc.o_err,       0);
        rst = 1'b1;
        step();
        check("idle_ready", ifc.o_sym_ready, 0);

        // Back-to-back block, long output stall, i_start in HOLD ignored
        ifc.i_start = 1'b1;
        step();
        ifc.i_start = 1'b0;
        check("fill_ready", ifc.o_sym_ready, 1);
        check("fill_busy",  ifc.o_busy,      1);
        n_acs = 0; n_sel = 0;
        ifc.i_sym_valid = 1'b1;
        repeat (16) step();
        ifc.i_sym_valid = 1'b0;
        check("b2b_acs",    n_acs,           16);
        check("b2b_sel",    ifc.o_en_sel,    1);
        check("b2b_cnt",    ifc.o_sym_cnt,   16);
        check("sel_en_t",   ifc.o_en_t,      0);
        check("sel_tbrst",  ifc.o_tb_rst,    0);
        check("sel_ready",  ifc.o_sym_ready, 0);
        step();
        check("trace_en_t", ifc.o_en_t,      1);
        check("trace_tbr",  ifc.o_tb_rst,    1);
        check("trace_sel",  ifc.o_en_sel,    0);
        check("sel_pulses", n_sel,           1);
        repeat (16) step();
        check("trace_wait", ifc.o_en_t,      1);
        check("trace_cnt",  ifc.o_sym_cnt,   16);
        ifc.i_tb_done = 1'b1;
        step();
        ifc.i_tb_done = 1'b0;
        check("hold_valid", ifc.o_out_valid, 1);
        check("hold_en_t",  ifc.o_en_t,      0);
        check("hold_tbrst", ifc.o_tb_rst,    1);
        n_ov = 0;
        for (int k = 0; k < 5; k++) begin
            ifc.i_start = (k == 2);
            step();
        end
        ifc.i_start = 1'b0;
        check("hold_ov_cyc", n_ov,            5);
        check("hold_still",  ifc.o_out_valid, 1);
        ifc.i_out_ready = 1'b1;
        step();
        ifc.i_out_ready = 1'b0;
        check("done_valid", ifc.o_out_valid, 0);
        check("done_busy",  ifc.o_busy,      0);
        check("done_cnt",   ifc.o_sym_cnt,   16);
        step();
        check("no_queue",   ifc.o_busy,      0);
        check("nowd_err",   ifc.o_err,       0);

        // Gapped symbols, stray i_start and i_tb_done during FILL
        ifc.i_start = 1'b1;
        step();
        ifc.i_start = 1'b0;
        check("gap_clear",  ifc.o_sym_cnt,   0);
        n_acs = 0; n_sel = 0;
        for (int i = 0; i < 46; i++) begin
            ifc.i_sym_valid = (i % 3 == 0);
            ifc.i_start     = (i == 7);
            ifc.i_tb_done   = (i == 10);
            step();
            check("gap_cnt", ifc.o_sym_cnt, i / 3 + 1);
        end
        ifc.i_sym_valid = 1'b0;
        ifc.i_start     = 1'b0;
        ifc.i_tb_done   = 1'b0;
        check("gap_acs",    n_acs,           16);
        check("gap_sel",    ifc.o_en_sel,    1);
        step();
        check("gap_en_t",   ifc.o_en_t,      1);
        check("gap_selcnt", n_sel,           1);

        // Reset in the middle of TRACE
        repeat (3) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mrst_busy",  ifc.o_busy,      0);
        check("mrst_en_t",  ifc.o_en_t,      0);
        check("mrst_tbrst", ifc.o_tb_rst,    0);
        check("mrst_cnt",   ifc.o_sym_cnt,   0);
        check("mrst_ready", ifc.o_sym_ready, 0);
        ifc.i_tb_done = 1'b1;
        step();
        ifc.i_tb_done = 1'b0;
        check("idle_done",  ifc.o_busy,      0);
        check("idle_ov",    ifc.o_out_valid, 0);

`ifdef VITERBI_CTRL_WATCHDOG_EN
        start_and_fill();
        step();
        check("wd_trace",   ifc.o_en_t,      1);
        n_ov = 0;
        repeat (19) step();
        check("wd_waiting", ifc.o_busy,      1);
        check("wd_err0",    ifc.o_err,       0);
        step();
        check("wd_idle",    ifc.o_busy,      0);
        check("wd_err",     ifc.o_err,       1);
        check("wd_no_ov",   n_ov,            0);
        start_and_fill();
        step();
        ifc.i_tb_done = 1'b1;
        step();
        ifc.i_tb_done = 1'b0;
        check("wd_hold",    ifc.o_out_valid, 1);
        check("wd_sticky",  ifc.o_err,       1);
        ifc.i_out_ready = 1'b1;
        step();
        ifc.i_out_ready = 1'b0;
        check("wd_sticky2", ifc.o_err,       1);
`else
        start_and_fill();
        step();
        repeat (40) step();
        check("nowd_wait",  ifc.o_en_t,      1);
        check("nowd_err2",  ifc.o_err,       0);
        ifc.i_tb_done = 1'b1;
        step();
        ifc.i_tb_done   = 1'b0;
        ifc.i_out_ready = 1'b1;
        step();
        ifc.i_out_ready = 1'b0;
        check("nowd_idle",  ifc.o_busy,      0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
